// File: rtl/usb_in_fifo_pkg.sv
// Shared definitions for the single-clock IN FIFO.
// Holds the byte width, the ceil_log2 sizing helper, and the widths that the
// default configuration derives from it (IN_LENGTH, PTRW, CNTW). Modules
// recompute the same widths from their own parameters with ceil_log2.
package usb_in_fifo_pkg;

  localparam int BYTE_W = 8;

  // Smallest r with 2**r >= n, never less than 1 so a 1-entry range still
  // gets a real bit.
  function automatic int ceil_log2(input int n);
    for (int r = 1; r < 32; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 32;
  endfunction

  localparam int DEF_IN_MAX_PACKET_SIZE = 8;
  localparam int DEF_APP_BYTES          = 2;
  localparam int DEF_IN_LENGTH          = DEF_IN_MAX_PACKET_SIZE + 1;
  localparam int DEF_PTRW               = ceil_log2(DEF_IN_LENGTH);
  localparam int DEF_CNTW               = ceil_log2(DEF_APP_BYTES + 1);

endpackage

// File: rtl/in_flush_timer.sv
// Idle-flush timer for the IN FIFO.
// Tracks whether bytes were written since the packet engine last took a
// snapshot (pending), counts clk_gate ticks while the staging register is
// empty, and emits a one-cycle flush pulse when the count reaches the timeout.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   clk_gate_i         bit-rate enable
//   drain_i            a byte moved from staging into the ring this cycle
//   accept_i           an application beat was accepted this cycle
//   in_ready_i         engine snapshot request (qualified by clk_gate_i)
//   stage_empty_i      staging register holds no bytes
//   in_flush_o         one-cycle pulse: send the partial packet now
module in_flush_timer
  import usb_in_fifo_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clk_gate_i,
  input  logic drain_i,
  input  logic accept_i,
  input  logic in_ready_i,
  input  logic stage_empty_i,
  output logic in_flush_o
);

  // A timeout of 0 disables flushing; TMAX keeps the counter sizing legal.
  localparam int TMAX = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT : 1;
  localparam int TW   = ceil_log2(TMAX + 1);
  localparam bit EN   = (FLUSH_TIMEOUT > 0);

  logic          r_pending;
  logic [TW-1:0] r_idle;
  logic          r_flush;
  logic          w_restart;
  logic          w_idle_tick;

  assign w_restart   = drain_i | accept_i;
  // Counter stops at TMAX, which is what prevents a repeat pulse.
  assign w_idle_tick = clk_gate_i & r_pending & stage_empty_i & (r_idle != TW'(TMAX));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pending <= 1'b0;
      r_idle    <= '0;
      r_flush   <= 1'b0;
    end else begin
      // A drain in the same tick as a snapshot keeps the flag set.
      if (drain_i)                       r_pending <= 1'b1;
      else if (clk_gate_i & in_ready_i)  r_pending <= 1'b0;

      if (w_restart)        r_idle <= '0;
      else if (w_idle_tick) r_idle <= r_idle + TW'(1);

      r_flush <= EN & ~w_restart & w_idle_tick & (r_idle == TW'(TMAX - 1));
    end
  end

  assign in_flush_o = r_flush;

endmodule

// File: rtl/in_fifo_sync_wide.sv
// Single-clock IN FIFO with a wide application port.
// The application hands over beats of up to APP_BYTES bytes; a staging
// register drains them one byte per enabled clk_gate tick into a circular
// byte ring read by the IN packet engine. An idle-flush timer asks the engine
// to send a short packet when the application stalls mid-packet.
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   clk_gate_i              bit-rate enable for all ring-side updates
//   in_full_i               engine reports ring full; hold the staged bytes
//   in_ready_i              engine snapshot of the write pointer
//   app_in_data_i           beat data, byte 0 in the LSBs is sent first
//   app_in_count_i          valid bytes in the beat (clamped to APP_BYTES)
//   app_in_valid_i/ready_o  beat handshake
//   in_fifo_o               ring contents
//   in_last_q_o             ring write pointer
//   in_last_qq_o            write pointer captured at the last snapshot
//   app_in_buffer_empty_o   staging register empty
//   in_flush_o              one-cycle partial-packet flush request
module in_fifo_sync_wide
  import usb_in_fifo_pkg::*;
#(
  parameter  int IN_MAX_PACKET_SIZE = 8,
  parameter  int APP_BYTES          = 2,
  parameter  int FLUSH_TIMEOUT      = 64,
  localparam int IN_LENGTH          = IN_MAX_PACKET_SIZE + 1,
  localparam int PTRW               = ceil_log2(IN_LENGTH),
  localparam int CNTW               = ceil_log2(APP_BYTES + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clk_gate_i,
  input  logic                          in_full_i,
  input  logic                          in_ready_i,
  input  logic [BYTE_W*APP_BYTES-1:0]   app_in_data_i,
  input  logic [CNTW-1:0]               app_in_count_i,
  input  logic                          app_in_valid_i,
  output logic                          app_in_ready_o,
  output logic [BYTE_W*IN_LENGTH-1:0]   in_fifo_o,
  output logic [PTRW-1:0]               in_last_q_o,
  output logic [PTRW-1:0]               in_last_qq_o,
  output logic                          app_in_buffer_empty_o,
  output logic                          in_flush_o
);

  // Counts above the beat width load a full beat.
  function automatic logic [CNTW-1:0] clamp_count(input logic [CNTW-1:0] c);
    if (c > CNTW'(APP_BYTES)) return CNTW'(APP_BYTES);
    return c;
  endfunction

  logic [BYTE_W*APP_BYTES-1:0] r_stage_data;
  logic [CNTW-1:0]             r_stage_cnt;
  logic [CNTW-1:0]             r_stage_idx;
  logic [BYTE_W*IN_LENGTH-1:0] r_in_fifo;
  logic [PTRW-1:0]             r_in_last;
  logic [PTRW-1:0]             r_in_last_qq;

  logic [PTRW-1:0]   w_in_last_next;
  logic [BYTE_W-1:0] w_stage_byte;
  logic              w_stage_empty;
  logic              w_drain;
  logic              w_accept;

  assign w_stage_empty = (r_stage_cnt == '0);
  assign w_drain       = clk_gate_i & ~in_full_i & ~w_stage_empty;
  // Ready also while the last staged byte leaves, so beats go back to back.
  assign app_in_ready_o = w_stage_empty | ((r_stage_cnt == CNTW'(1)) & w_drain);
  assign w_accept       = app_in_valid_i & app_in_ready_o;

  assign w_in_last_next = !w_drain ? r_in_last :
                          (r_in_last == PTRW'(IN_LENGTH - 1)) ? '0 :
                          r_in_last + PTRW'(1);

  always_comb begin
    w_stage_byte = '0;
    for (int i = 0; i < APP_BYTES; i++) begin
      if (r_stage_idx == CNTW'(i)) w_stage_byte = r_stage_data[BYTE_W*i +: BYTE_W];
    end
  end

  // Staging register: accept takes priority, since an accept coinciding with
  // a drain only happens when the old beat's last byte is leaving.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stage_data <= '0;
      r_stage_cnt  <= '0;
      r_stage_idx  <= '0;
    end else if (w_accept) begin
      r_stage_data <= app_in_data_i;
      r_stage_cnt  <= clamp_count(app_in_count_i);
      r_stage_idx  <= '0;
    end else if (w_drain) begin
      r_stage_cnt  <= r_stage_cnt - CNTW'(1);
      r_stage_idx  <= r_stage_idx + CNTW'(1);
    end
  end

  // Ring side: write pointer, byte ring, and the engine snapshot, which sees
  // the pointer after this tick's byte has been counted.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_in_fifo    <= '0;
      r_in_last    <= '0;
      r_in_last_qq <= '0;
    end else begin
      r_in_last <= w_in_last_next;
      if (clk_gate_i & in_ready_i) r_in_last_qq <= w_in_last_next;
      for (int i = 0; i < IN_LENGTH; i++) begin
        if (w_drain && (r_in_last == PTRW'(i))) r_in_fifo[BYTE_W*i +: BYTE_W] <= w_stage_byte;
      end
    end
  end

  in_flush_timer #(
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .clk_gate_i    (clk_gate_i),
    .drain_i       (w_drain),
    .accept_i      (w_accept),
    .in_ready_i    (in_ready_i),
    .stage_empty_i (w_stage_empty),
    .in_flush_o    (in_flush_o)
  );

  assign in_fifo_o             = r_in_fifo;
  assign in_last_q_o           = r_in_last;
  assign in_last_qq_o          = r_in_last_qq;
  assign app_in_buffer_empty_o = w_stage_empty;

endmodule

// File: tb/tb_in_fifo_sync_wide.sv
module tb_in_fifo_sync_wide;

  localparam int LEN = 9;
  localparam int TO  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: APP_BYTES=4, FLUSH_TIMEOUT=3
  logic        rst_n, gate, full, rdy, valid;
  logic [31:0] data;
  logic [2:0]  cnt;
  logic        ready, empty, flush;
  logic [71:0] fifo;
  logic [3:0]  last, lastqq;

  in_fifo_sync_wide #(.IN_MAX_PACKET_SIZE(8), .APP_BYTES(4), .FLUSH_TIMEOUT(TO)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .clk_gate_i(gate), .in_full_i(full), .in_ready_i(rdy),
    .app_in_data_i(data), .app_in_count_i(cnt), .app_in_valid_i(valid), .app_in_ready_o(ready),
    .in_fifo_o(fifo), .in_last_q_o(last), .in_last_qq_o(lastqq),
    .app_in_buffer_empty_o(empty), .in_flush_o(flush));

  // Second DUT: APP_BYTES=1, flushing disabled, gate always high
  logic        rst2_n, gate2, full2, rdy2, valid2;
  logic [7:0]  data2;
  logic [0:0]  cnt2;
  logic        ready2, empty2, flush2;
  logic [71:0] fifo2;
  logic [3:0]  last2, lastqq2;

  in_fifo_sync_wide #(.IN_MAX_PACKET_SIZE(8), .APP_BYTES(1), .FLUSH_TIMEOUT(0)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst2_n), .clk_gate_i(gate2), .in_full_i(full2), .in_ready_i(rdy2),
    .app_in_data_i(data2), .app_in_count_i(cnt2), .app_in_valid_i(valid2), .app_in_ready_o(ready2),
    .in_fifo_o(fifo2), .in_last_q_o(last2), .in_last_qq_o(lastqq2),
    .app_in_buffer_empty_o(empty2), .in_flush_o(flush2));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes accepted but not yet in the ring, the ring image,
  // pointer, snapshot and flush bookkeeping.
  logic [7:0] exp_q[$];
  logic [7:0] ring[LEN];
  int  mptr = 0, mqq = 0, idle = 0;
  bit  pend = 0;
  int  acc_n = 0;
  bit  acc_f = 0, last_acc = 0;
  bit  mon_en = 0, rnd_mode = 0, done2 = 0;
  int  flush_seen = 0, cyc = 0, gmode = 0;

  function automatic logic [71:0] ring_packed();
    logic [71:0] v;
    for (int i = 0; i < LEN; i++) v[8*i +: 8] = ring[i];
    return v;
  endfunction

  // One clock: handshake observed at +4, inputs updated at +2 after the edge.
  task automatic tick();
    int n;
    #2;
    if (valid && ready) begin
      n = (cnt > 3'd4) ? 4 : int'(cnt);
      for (int j = 0; j < n; j++) exp_q.push_back(data[8*j +: 8]);
      acc_n = n;
      acc_f = 1;
    end
    @(posedge clk);
    #2;
    last_acc = acc_f;
    if (acc_f) valid = 1'b0;
    acc_f = 0;
    acc_n = 0;
    cyc++;
    case (gmode)
      0:       gate = (cyc % 4 == 0);
      1:       gate = 1'b1;
      default: gate = 1'($urandom_range(0, 1));
    endcase
    if (rnd_mode) begin
      full = ($urandom_range(0, 3) == 0);
      rdy  = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [2:0] c);
    bit got;
    got   = 0;
    data  = d;
    cnt   = c;
    valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (last_acc) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL send_beat: beat %0h not accepted within 400 cycles", d);
      valid = 1'b0;
    end
  endtask

  task automatic wait_size(input int target);
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == target) return;
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_size: staged %0d never reached %0d", exp_q.size(), target);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    bit en_c, g, f, r, af, drn, pnew, efl;
    int an, sb, sz;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      en_c = mon_en; g = gate; f = full; r = rdy; af = acc_f; an = acc_n;
      sb = exp_q.size() - an;
      #1;
      if (en_c && mon_en) begin
        drn = g && !f && (sb > 0);
        if (drn) begin
          b = exp_q.pop_front();
          ring[mptr] = b;
          mptr = (mptr + 1) % LEN;
        end
        chk("wr_ptr", last, mptr);
        if (drn) chk("ring", fifo, ring_packed());
        if (g && r) mqq = mptr;
        chk("snap_ptr", lastqq, mqq);
        efl  = 0;
        pnew = drn ? 1'b1 : ((g && r) ? 1'b0 : pend);
        if (drn || af) idle = 0;
        else if (g && pend && sb == 0 && idle < TO) begin
          idle++;
          efl = (idle == TO);
        end
        pend = pnew;
        chk("flush", flush, efl);
        if (flush) flush_seen++;
        sz = exp_q.size();
        chk("empty", empty, sz == 0);
      end
      #2;
      if (en_c && mon_en) begin
        sz = exp_q.size();
        chk("ready", ready, (sz == 0) || (sz == 1 && gate && !full));
      end
    end
  end

  // Second DUT: one byte per cycle, written one cycle after acceptance
  initial begin : dut2_check
    logic [7:0] d_prev, d_cur;
    int p2;
    gate2 = 1'b1; full2 = 1'b0; rdy2 = 1'b0; valid2 = 1'b1; cnt2 = 1'b1; data2 = 8'h00;
    p2 = 0;
    wait (rst2_n);
    @(posedge clk);
    d_prev = data2;
    #1;
    chk("ab1_first_ptr", last2, 0);
    #1;
    data2 = 8'($urandom);
    repeat (300) begin
      @(posedge clk);
      d_cur = data2;
      #1;
      chk("ab1_ring", fifo2[8*p2 +: 8], d_prev);
      p2 = (p2 + 1) % LEN;
      chk("ab1_ptr", last2, p2);
      chk("ab1_ready", ready2, 1'b1);
      chk("ab1_empty", empty2, 1'b0);
      chk("ab1_flush", flush2, 1'b0);
      chk("ab1_snap", lastqq2, 0);
      d_prev = d_cur;
      #1;
      data2 = 8'($urandom);
    end
    done2 = 1;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0; rst2_n = 1'b0;
    gate = 1'b0; full = 1'b0; rdy = 1'b0; valid = 1'b0; data = '0; cnt = '0;
    foreach (ring[i]) ring[i] = 8'h00;
    #12;
    chk("rst_fifo", fifo, 0);
    chk("rst_ptr", last, 0);
    chk("rst_snap", lastqq, 0);
    chk("rst_flush", flush, 0);
    chk("rst_empty", empty, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1; rst2_n = 1'b1; mon_en = 1;
    chk("rst_ready", ready, 1);

    // Basic fill
    send_beat(32'h44332211, 3'd4);
    repeat (20) tick();
    chk("fill_ptr", last, 4);
    chk("fill_bytes", fifo[31:0], 32'h44332211);

    // Asynchronous reset with bytes still staged
    send_beat(32'hDDCCBBAA, 3'd4);
    wait_size(3);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_fifo", fifo, 0);
    chk("mid_rst_ptr", last, 0);
    chk("mid_rst_snap", lastqq, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_empty", empty, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    foreach (ring[i]) ring[i] = 8'h00;
    mptr = 0; mqq = 0; pend = 0; idle = 0;
    mon_en = 1;
    tick();
    chk("post_rst_ready", ready, 1);
    chk("post_rst_empty", empty, 1);

    // Wrap-around: 12 bytes from pointer 0
    send_beat(32'h04030201, 3'd4);
    send_beat(32'h08070605, 3'd4);
    send_beat(32'h0C0B0A09, 3'd4);
    repeat (24) tick();
    chk("wrap_ptr", last, 3);
    chk("wrap_idx8", fifo[71:64], 8'h09);
    chk("wrap_idx0", fifo[7:0], 8'h0A);

    // Backpressure after two bytes
    send_beat(32'h5D5C5B5A, 3'd4);
    wait_size(2);
    full = 1'b1;
    repeat (12) tick();
    chk("bp_ptr", last, 5);
    chk("bp_ready", ready, 0);
    chk("bp_empty", empty, 0);
    full = 1'b0;
    repeat (20) tick();
    chk("bp_ptr_after", last, 7);
    chk("bp_ready_after", ready, 1);

    // count=0 beat is swallowed
    send_beat(32'hFFFFFFFF, 3'd0);
    repeat (8) tick();
    chk("cnt0_ptr", last, 7);
    chk("cnt0_ring", fifo, ring_packed());

    // count=7 clamps to four bytes
    send_beat(32'hF4F3F2F1, 3'd7);
    repeat (20) tick();
    chk("cnt7_ptr", last, 2);
    chk("cnt7_idx7", fifo[63:56], 8'hF1);
    chk("cnt7_idx8", fifo[71:64], 8'hF2);
    chk("cnt7_idx0", fifo[7:0], 8'hF3);
    chk("cnt7_idx1", fifo[15:8], 8'hF4);

    // Flush after a stall, exactly once
    flush_seen = 0;
    send_beat(32'h0000BEEF, 3'd2);
    repeat (40) tick();
    chk("flush_once", flush_seen, 1);

    // Snapshot before timeout cancels the flush
    flush_seen = 0;
    rdy = 1'b1;
    send_beat(32'h00001234, 3'd2);
    repeat (40) tick();
    rdy = 1'b0;
    chk("flush_cancel", flush_seen, 0);

    // Randomised traffic
    rnd_mode = 1;
    for (int b = 0; b < 300; b++) begin
      gmode = $urandom_range(0, 2);
      send_beat($urandom, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 5)) tick();
    end
    rnd_mode = 0; full = 1'b0; rdy = 1'b0; gmode = 0;
    tick();
    wait_size(0);
    repeat (4) tick();
    chk("leftover", exp_q.size(), 0);

    for (int k = 0; k < 2000 && !done2; k++) @(posedge clk);
    chk("ab1_done", done2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
